// File: rtl/tcp_tx.sv
// TCP/IPv4-over-Ethernet frame transmitter: wraps a streamed payload in a 54-byte
// header, pads short frames to 60 bytes and emits one byte per output beat.
module tcp_tx #(
  parameter logic [47:0] mac    = 48'h000000000000,
  parameter logic [31:0] ip     = 32'h11223344,
  parameter logic [15:0] port   = 16'd80,
  parameter logic [15:0] window = 16'hFFFF
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        start,
  output logic        busy,
  input  logic [47:0] dstMac,
  input  logic [31:0] dstIp,
  input  logic [15:0] dstPort,
  input  logic [31:0] seq,
  input  logic [31:0] ack,
  input  logic [7:0]  flags,
  input  logic [15:0] tcpChk,
  input  logic [10:0] payloadLen,
  input  logic        inValid,
  input  logic [7:0]  inData,
  output logic        inReady,
  output logic        outValid,
  output logic [7:0]  outData,
  output logic        outLast,
  input  logic        outReady,
  output logic [7:0]  frameCount,
  output logic [7:0]  errCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    PAD     = 2'd3
  } state_t;

  localparam logic [10:0] MAX_PAYLOAD = 11'd1460;
  localparam logic [10:0] HDR_LEN     = 11'd54;
  localparam logic [10:0] MIN_FRAME   = 11'd60;
  localparam logic [10:0] MIN_PAYLOAD = 11'd6;
  localparam logic [3:0]  CHK_WORDS   = 4'd9;

  // Ones'-complement 16-bit add with end-around carry.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] id_q, id_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] ack_q, ack_d;
  logic [7:0]  flags_q, flags_d;
  logic [15:0] tcp_chk_q, tcp_chk_d;
  logic [10:0] len_q, len_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]  chk_step_q, chk_step_d;
  logic [15:0] chk_acc_q, chk_acc_d;

  logic         adv_s;
  logic [15:0]  tot_len_s;
  logic [15:0]  ip_chk_s;
  logic [15:0]  chk_word_s;
  logic [10:0]  frame_len_s;
  logic [10:0]  pay_end_s;
  logic         last_byte_s;
  logic         more_pay_s;
  logic [431:0] hdr_s;
  logic [8:0]   hdr_lsb_s;
  logic [7:0]   hdr_byte_s;
  logic         emit_s;
  logic [7:0]   emit_byte_s;
  logic         in_ready_s;

  assign adv_s       = !out_valid_q || outReady;
  assign tot_len_s   = 16'd40 + {5'd0, len_q};
  assign ip_chk_s    = ~chk_acc_q;
  assign frame_len_s = (len_q < MIN_PAYLOAD) ? MIN_FRAME : (HDR_LEN + len_q);
  assign pay_end_s   = HDR_LEN + len_q - 11'd1;
  assign last_byte_s = (byte_cnt_q == (frame_len_s - 11'd1));
  assign more_pay_s  = (byte_cnt_q < (HDR_LEN + len_q));
  assign in_ready_s  = (state_q == PAYLOAD) && adv_s && more_pay_s;

  assign hdr_s = {dst_mac_q, mac, 16'h0800,
                  16'h4500, tot_len_s, id_q, 16'h4000, 8'h40, 8'h06, ip_chk_s, ip, dst_ip_q,
                  port, dst_port_q, seq_q, ack_q, 8'h50, flags_q, window, tcp_chk_q, 16'h0000};
  assign hdr_lsb_s  = 9'd424 - {byte_cnt_q[5:0], 3'b000};
  assign hdr_byte_s = hdr_s[hdr_lsb_s +: 8];

  // IP header words folded into the checksum, one per cycle after start.
  always_comb begin
    case (chk_step_q)
      4'd0:    chk_word_s = 16'h4500;
      4'd1:    chk_word_s = tot_len_s;
      4'd2:    chk_word_s = id_q;
      4'd3:    chk_word_s = 16'h4000;
      4'd4:    chk_word_s = 16'h4006;
      4'd5:    chk_word_s = ip[31:16];
      4'd6:    chk_word_s = ip[15:0];
      4'd7:    chk_word_s = dst_ip_q[31:16];
      4'd8:    chk_word_s = dst_ip_q[15:0];
      default: chk_word_s = 16'h0000;
    endcase
  end

  // Byte source for the current state; payload beats only exist when a byte is offered.
  always_comb begin
    emit_s      = 1'b0;
    emit_byte_s = 8'h00;
    case (state_q)
      HDR: begin
        emit_s      = 1'b1;
        emit_byte_s = hdr_byte_s;
      end
      PAYLOAD: begin
        emit_s      = inValid && more_pay_s;
        emit_byte_s = inData;
      end
      PAD: begin
        emit_s      = 1'b1;
        emit_byte_s = 8'h00;
      end
      default: begin
        emit_s      = 1'b0;
        emit_byte_s = 8'h00;
      end
    endcase
  end

  // Frame sequencing, output register loading and counters.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    out_data_d  = out_data_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    id_d        = id_q;
    dst_mac_d   = dst_mac_q;
    dst_ip_d    = dst_ip_q;
    dst_port_d  = dst_port_q;
    seq_d       = seq_q;
    ack_d       = ack_q;
    flags_d     = flags_q;
    tcp_chk_d   = tcp_chk_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;

    if (busy_q && (chk_step_q < CHK_WORDS)) begin
      chk_acc_d  = csum_add(chk_acc_q, chk_word_s);
      chk_step_d = chk_step_q + 4'd1;
    end else begin
      chk_acc_d  = chk_acc_q;
      chk_step_d = chk_step_q;
    end

    // An accepted (or empty) output slot is cleared unless refilled below.
    if (adv_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (payloadLen > MAX_PAYLOAD) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            dst_mac_d  = dstMac;
            dst_ip_d   = dstIp;
            dst_port_d = dstPort;
            seq_d      = seq;
            ack_d      = ack;
            flags_d    = flags;
            tcp_chk_d  = tcpChk;
            len_d      = payloadLen;
            byte_cnt_d = 11'd0;
            chk_step_d = 4'd0;
            chk_acc_d  = 16'h0000;
            busy_d     = 1'b1;
            state_d    = HDR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HDR, PAYLOAD, PAD: begin
        if (adv_s && out_last_q) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          id_d        = id_q + 16'd1;
        end else if (adv_s && emit_s && (byte_cnt_q < frame_len_s)) begin
          out_valid_d = 1'b1;
          out_data_d  = emit_byte_s;
          out_last_d  = last_byte_s;
          byte_cnt_d  = byte_cnt_q + 11'd1;
          if ((state_q == HDR) && (byte_cnt_q == (HDR_LEN - 11'd1))) begin
            state_d = (len_q != 11'd0) ? PAYLOAD : PAD;
          end else if ((state_q == PAYLOAD) && (byte_cnt_q == pay_end_s) && !last_byte_s) begin
            state_d = PAD;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      frame_cnt_q <= 8'h00;
      err_cnt_q   <= 8'h00;
      id_q        <= 16'h0000;
      dst_mac_q   <= 48'h000000000000;
      dst_ip_q    <= 32'h00000000;
      dst_port_q  <= 16'h0000;
      seq_q       <= 32'h00000000;
      ack_q       <= 32'h00000000;
      flags_q     <= 8'h00;
      tcp_chk_q   <= 16'h0000;
      len_q       <= 11'd0;
      byte_cnt_q  <= 11'd0;
      chk_step_q  <= 4'd0;
      chk_acc_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      id_q        <= id_d;
      dst_mac_q   <= dst_mac_d;
      dst_ip_q    <= dst_ip_d;
      dst_port_q  <= dst_port_d;
      seq_q       <= seq_d;
      ack_q       <= ack_d;
      flags_q     <= flags_d;
      tcp_chk_q   <= tcp_chk_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      chk_step_q  <= chk_step_d;
      chk_acc_q   <= chk_acc_d;
    end
  end

  assign busy       = busy_q;
  assign inReady    = in_ready_s;
  assign outValid   = out_valid_q;
  assign outData    = out_data_q;
  assign outLast    = out_last_q;
  assign frameCount = frame_cnt_q;
  assign errCount   = err_cnt_q;

endmodule

// File: tb/tb_tcp_tx.sv
// Scoreboard bench for tcp_tx: expected frame bytes are queued when a frame is
// requested and compared byte by byte as the sink accepts them.
module tb_tcp_tx;

  localparam logic [47:0] SRC_MAC  = 48'h000000000000;
  localparam logic [31:0] SRC_IP   = 32'h11223344;
  localparam logic [15:0] SRC_PORT = 16'd80;
  localparam logic [15:0] WIN      = 16'hFFFF;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic [47:0] dstMac = 48'h0;
  logic [31:0] dstIp = 32'h0;
  logic [15:0] dstPort = 16'h0;
  logic [31:0] seq = 32'h0;
  logic [31:0] ack = 32'h0;
  logic [7:0]  flags = 8'h0;
  logic [15:0] tcpChk = 16'h0;
  logic [10:0] payloadLen = 11'd0;
  logic        inValid = 1'b0;
  logic [7:0]  inData = 8'h0;
  logic        inReady;
  logic        outValid;
  logic [7:0]  outData;
  logic        outLast;
  logic        outReady = 1'b1;
  logic [7:0]  frameCount;
  logic [7:0]  errCount;

  always #5 CLOCK = ~CLOCK;

  tcp_tx dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start), .busy(busy),
    .dstMac(dstMac), .dstIp(dstIp), .dstPort(dstPort), .seq(seq), .ack(ack),
    .flags(flags), .tcpChk(tcpChk), .payloadLen(payloadLen),
    .inValid(inValid), .inData(inData), .inReady(inReady),
    .outValid(outValid), .outData(outData), .outLast(outLast), .outReady(outReady),
    .frameCount(frameCount), .errCount(errCount)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  cap[$];
  logic [7:0]  pay[$];
  int          pay_idx = 0;
  bit          rand_ready = 1'b0;
  bit          rand_valid = 1'b0;
  bit          frame_done = 1'b0;
  bit          held_v = 1'b0;
  logic [7:0]  held_d = 8'h0;
  logic [15:0] id_exp = 16'h0;

  function automatic logic [15:0] ref_ip_chk(input logic [15:0] tl, input logic [15:0] id,
                                             input logic [31:0] dip);
    int unsigned s;
    s = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h4006 + 32'(SRC_IP[31:16]) +
        32'(SRC_IP[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  // Queue the whole expected frame for the current header inputs and payload.
  task automatic build_frame(input logic [10:0] len);
    logic [431:0] h;
    logic [15:0]  tl;
    int           total;
    tl = 16'd40 + 16'(len);
    h = {dstMac, SRC_MAC, 16'h0800, 16'h4500, tl, id_exp, 16'h4000, 8'h40, 8'h06,
         ref_ip_chk(tl, id_exp, dstIp), SRC_IP, dstIp, SRC_PORT, dstPort, seq, ack,
         8'h50, flags, WIN, tcpChk, 16'h0000};
    for (int i = 0; i < 54; i++) exp_q.push_back(h[431 - 8*i -: 8]);
    for (int i = 0; i < int'(len); i++) exp_q.push_back(pay[i]);
    total = 54 + int'(len);
    for (int i = total; i < 60; i++) exp_q.push_back(8'h00);
  endtask

  task automatic set_hdr(input int k);
    dstMac  = 48'hA0B1C2D3E400 + 48'(k);
    dstIp   = 32'h0A000001;
    dstPort = 16'h1F90 + 16'(k);
    seq     = $urandom;
    ack     = $urandom;
    flags   = 8'h18;
    tcpChk  = 16'(($urandom));
  endtask

  // One clock: monitor at the falling edge, drive new inputs just after the rising edge.
  task automatic step();
    bit         fire;
    logic [7:0] e;
    @(negedge CLOCK);
    if (held_v) begin
      checks++;
      if (outValid !== 1'b1 || outData !== held_d) begin
        errors++;
        $display("FAIL stall_hold: outValid=%b outData=%h, required 1/%h", outValid, outData, held_d);
      end
    end
    if (outValid === 1'b1 && outReady === 1'b1) begin
      cap.push_back(outData);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got %h, required no byte", outData);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (outData !== e) begin
          errors++;
          $display("FAIL byte[%0d]: got %h, required %h", cap.size() - 1, outData, e);
        end
        checks++;
        if (outLast !== (exp_q.size() == 0)) begin
          errors++;
          $display("FAIL last[%0d]: got %b, required %b", cap.size() - 1, outLast, exp_q.size() == 0);
        end
      end
      if (outLast === 1'b1) frame_done = 1'b1;
    end
    held_v = (outValid === 1'b1) && (outReady === 1'b0);
    held_d = outData;
    fire   = (inValid === 1'b1) && (inReady === 1'b1);
    @(posedge CLOCK);
    #1;
    if (fire) pay_idx++;
    outReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pay_idx < pay.size()) begin
      inValid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      inData  = pay[pay_idx];
    end else begin
      inValid = 1'b0;
      inData  = 8'h00;
    end
  endtask

  task automatic send_frame(input logic [10:0] len, input int budget, input bit poke_busy);
    payloadLen = len;
    build_frame(len);
    cap.delete();
    pay_idx    = 0;
    frame_done = 1'b0;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < budget && !frame_done; c++) begin
      if (poke_busy) begin
        start      = (c >= 5 && c < 10);
        payloadLen = 11'd1461;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL frame_timeout: %0d bytes left, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_frame: got %b, required 0", busy);
    end
    id_exp++;
  endtask

  task automatic test_reset();
    RESET_N  = 1'b0;
    outReady = 1'b1;
    #1;
    checks++;
    if ({busy, inReady, outValid, outLast} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {busy, inReady, outValid, outLast});
    end
    checks++;
    if (outData !== 8'h00) begin
      errors++;
      $display("FAIL reset_outData: got %h, required 00", outData);
    end
    checks++;
    if (frameCount !== 8'd0 || errCount !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d, required 0/0", frameCount, errCount);
    end
    repeat (3) @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_min_frame();
    pay.delete();
    set_hdr(1);
    send_frame(11'd0, 200, 1'b0);
    checks++;
    if (cap.size() != 60) begin
      errors++;
      $display("FAIL min_len: got %0d, required 60", cap.size());
    end else begin
      checks++;
      if ({cap[16], cap[17], cap[18], cap[19]} !== 32'h00280000) begin
        errors++;
        $display("FAIL min_totlen_id: got %h%h%h%h, required 00280000", cap[16], cap[17], cap[18], cap[19]);
      end
      checks++;
      if ({cap[24], cap[25]} !== 16'hEC69) begin
        errors++;
        $display("FAIL min_ipchk: got %h%h, required EC69", cap[24], cap[25]);
      end
      checks++;
      if ({cap[54], cap[55], cap[56], cap[57], cap[58], cap[59]} !== 48'h0) begin
        errors++;
        $display("FAIL min_pad: got nonzero pad bytes, required 00");
      end
    end
    checks++;
    if (frameCount !== 8'd1) begin
      errors++;
      $display("FAIL min_frameCount: got %0d, required 1", frameCount);
    end
  endtask

  task automatic test_payload10();
    pay.delete();
    for (int i = 1; i <= 10; i++) pay.push_back(8'(i));
    set_hdr(2);
    send_frame(11'd10, 300, 1'b0);
    checks++;
    if (cap.size() != 64) begin
      errors++;
      $display("FAIL p10_len: got %0d, required 64", cap.size());
    end else begin
      checks++;
      if ({cap[16], cap[17], cap[18], cap[19]} !== 32'h00320001) begin
        errors++;
        $display("FAIL p10_totlen_id: got %h%h%h%h, required 00320001", cap[16], cap[17], cap[18], cap[19]);
      end
      checks++;
      if (cap[54] !== 8'h01 || cap[63] !== 8'h0A) begin
        errors++;
        $display("FAIL p10_payload_ends: got %h..%h, required 01..0A", cap[54], cap[63]);
      end
    end
    checks++;
    if (frameCount !== 8'd2) begin
      errors++;
      $display("FAIL p10_frameCount: got %0d, required 2", frameCount);
    end
  endtask

  task automatic test_stall_back_to_back();
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    pay.delete();
    for (int i = 0; i < 100; i++) pay.push_back(8'($urandom));
    set_hdr(3);
    send_frame(11'd100, 3000, 1'b0);
    checks++;
    if (cap.size() != 154) begin
      errors++;
      $display("FAIL stall_len: got %0d, required 154", cap.size());
    end
    pay.delete();
    for (int i = 0; i < 3; i++) pay.push_back(8'hC0 + 8'(i));
    set_hdr(4);
    send_frame(11'd3, 2000, 1'b0);
    checks++;
    if (cap.size() != 60 || frameCount !== 8'd4) begin
      errors++;
      $display("FAIL b2b_len_count: got %0d/%0d, required 60/4", cap.size(), frameCount);
    end
    rand_ready = 1'b0;
    rand_valid = 1'b0;
  endtask

  task automatic test_errors();
    pay.delete();
    payloadLen = 11'd1461;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || errCount !== 8'd1) begin
      errors++;
      $display("FAIL oversize: busy=%b errCount=%0d, required 0/1", busy, errCount);
    end
    repeat (10) step();
    set_hdr(5);
    send_frame(11'd0, 300, 1'b1);
    checks++;
    if (errCount !== 8'd1 || frameCount !== 8'd5 || cap.size() != 60) begin
      errors++;
      $display("FAIL start_while_busy: err=%0d frames=%0d len=%0d, required 1/5/60", errCount, frameCount, cap.size());
    end
  endtask

  task automatic test_reset_mid();
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'h30 + 8'(i));
    set_hdr(6);
    payloadLen = 11'd20;
    build_frame(11'd20);
    cap.delete();
    pay_idx = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 200 && cap.size() < 31; c++) step();
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({busy, outValid, outLast, inReady} !== 4'b0000 || outData !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: got %b/%h, required 0000/00", {busy, outValid, outLast, inReady}, outData);
    end
    checks++;
    if (frameCount !== 8'd0 || errCount !== 8'd0) begin
      errors++;
      $display("FAIL midreset_counts: got %0d/%0d, required 0/0", frameCount, errCount);
    end
    exp_q.delete();
    held_v = 1'b0;
    id_exp = 16'h0000;
    repeat (2) step();
    RESET_N = 1'b1;
    repeat (2) step();
    pay.delete();
    set_hdr(7);
    send_frame(11'd0, 200, 1'b0);
    checks++;
    if (cap.size() != 60 || {cap[18], cap[19]} !== 16'h0000 || frameCount !== 8'd1) begin
      errors++;
      $display("FAIL post_reset_frame: len=%0d id=%h%h frames=%0d, required 60/0000/1", cap.size(), cap[18], cap[19], frameCount);
    end
  endtask

  initial begin
    test_reset();
    test_min_frame();
    test_payload10();
    test_stall_back_to_back();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_tx.md
TCP_TX -- requirements
Module: tcp_tx

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- mac, 48'h000000000000, source MAC.
- ip, 32'h11223344, source IPv4 address.
- port, 16'd80, source TCP port.
- window, 16'hFFFF, advertised TCP window.

REQ-002 Ports, one per line: name, direction, width, meaning.
- CLOCK, in, 1, sole clock, rising edge.
- RESET_N, in, 1, asynchronous active-low reset.
- start, in, 1, frame request, sampled when busy=0.
- busy, out, 1, frame in progress.
- dstMac, in, 48, destination MAC.
- dstIp, in, 32, destination IPv4 address.
- dstPort, in, 16, destination TCP port.
- seq, in, 32, TCP sequence number.
- ack, in, 32, TCP acknowledgement number.
- flags, in, 8, TCP flags byte.
- tcpChk, in, 16, TCP checksum supplied by the caller.
- payloadLen, in, 11, payload byte count.
- inValid, in, 1, payload byte valid.
- inData, in, 8, payload byte.
- inReady, out, 1, payload byte accepted when inValid&inReady.
- outValid, out, 1, frame byte valid.
- outData, out, 8, frame byte.
- outLast, out, 1, final byte of frame.
- outReady, in, 1, sink accepts byte.
- frameCount, out, 8, frames sent, wraps.
- errCount, out, 8, rejected starts, wraps.

Function
REQ-003 On start=1 with busy=0 and payloadLen<=1460, the block SHALL latch all header inputs, set busy=1 the next cycle, and enter HDR.
REQ-004 On start with payloadLen>1460, the block SHALL stay IDLE and increment errCount.
REQ-005 A start asserted while busy=1 SHALL be ignored, with no counter change.
REQ-006 States SHALL be IDLE, HDR, PAYLOAD, PAD; the advance condition is adv = !outValid | outReady.
REQ-007 outData/outValid/outLast SHALL be registered; the output SHALL hold stable while outValid&!outReady.
REQ-008 HDR SHALL emit 54 bytes, big-endian, one per adv cycle, in this order:
- dstMac, then mac.
- ethertype 08 00.
- 45 00; total length = 40+payloadLen; ID; 40 00 (DF); TTL 40; protocol 06; IP checksum; ip; dstIp.
- port, dstPort, seq, ack.
- data offset 50, flags, window, tcpChk, urgent pointer 00 00.
REQ-009 ID SHALL be an internal 16-bit counter, 0 after reset, incremented once per completed frame, wrapping FFFF->0000.
REQ-010 IP checksum SHALL be the ones'-complement of the end-around-carry-folded 16-bit sum of the nine non-checksum header words.
REQ-011 The IP checksum SHALL be computed sequentially after start and SHALL be valid before its first byte is emitted.
REQ-012 PAYLOAD SHALL assert inReady = adv, and SHALL copy each accepted inData to outData with outValid=1.
REQ-013 PAYLOAD SHALL insert a bubble (outValid=0) when inValid=0.
REQ-014 When payloadLen=0, the block SHALL go from HDR directly to PAD or end.
REQ-015 If header+payload <60 bytes, PAD SHALL emit 00 bytes until frame length is 60; padding SHALL NOT be counted in IP total length.
REQ-016 No FCS SHALL be generated.
REQ-017 outLast SHALL be 1 only on the final byte, whether that is a header, payload or pad byte.
REQ-018 When outLast is accepted, the block SHALL return to IDLE, set busy=0, increment frameCount and increment ID.
REQ-019 A new start SHALL be accepted the cycle after busy falls.
REQ-020 inReady SHALL be 0 in IDLE, HDR and PAD.

Reset
REQ-021 While RESET_N=0, asynchronously, the block SHALL force:
- state IDLE;
- busy=0, inReady=0, outValid=0, outLast=0, outData=00;
- frameCount=0, errCount=0, ID=0;
- latched header fields cleared.
REQ-022 Reset mid-frame SHALL abandon the frame with no counter increment.
REQ-023 After reset release, the first start SHALL produce ID 0000.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset defaults; ip=11223344, dstIp=0A000001, payloadLen=0, outReady=1 -> 60 bytes; bytes 16-17 = 00 28; ID 0000; checksum bytes 24-25 = EC 69; bytes 54-59 = 00; outLast on byte 59; frameCount=1.
- payloadLen=10, bytes 01..0A, outReady=1 -> 64 bytes; total length 00 32; payload 01..0A at offsets 54-63; no pad; second frame ID 0001.
- Random outReady toggling, payloadLen=100, inValid gaps -> byte sequence identical to stall-free run; no byte dropped or duplicated; outData stable while stalled.
- start with payloadLen=1461 -> errCount=1, busy stays 0, no output; start during busy -> ignored.
- RESET_N low at byte 30 -> outputs zero immediately; next frame well-formed with ID 0000 and frameCount 1.
